// File: rtl/pingpong_if.sv
// pingpong_if: sample stream, output stream, RAM port and status bundle of the ping-pong controller.
interface pingpong_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;
    logic                  ram_ena;
    logic [ADDR_W:0]       ram_addra;
    logic [DATA_WIDTH-1:0] ram_dina;
    logic                  ram_enb;
    logic [ADDR_W:0]       ram_addrb;
    logic [DATA_WIDTH-1:0] ram_doutb;
    logic [1:0]            bank_full;
    logic                  err_len;

    modport slave (
        input  s_valid, s_data, s_last, m_ready, ram_doutb,
        output s_ready, m_valid, m_data, m_last, ram_ena, ram_addra, ram_dina,
               ram_enb, ram_addrb, bank_full, err_len
    );

    modport master (
        output s_valid, s_data, s_last, m_ready, ram_doutb,
        input  s_ready, m_valid, m_data, m_last, ram_ena, ram_addra, ram_dina,
               ram_enb, ram_addrb, bank_full, err_len
    );
endinterface

// File: rtl/pingpong_ram_ctrl.sv
// pingpong_ram_ctrl: double-buffer controller, writer fills one RAM bank while the reader drains the other.
// Define PINGPONG_BITREV_RD_EN to read each bank in bit-reversed address order.
module pingpong_ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 256,
    parameter int ADDR_W     = 8
) (
    input logic       clk,
    input logic       rst_n,
    pingpong_if.slave bus
);
    typedef enum logic [1:0] {R_IDLE, R_STREAM, R_DRAIN} rd_state_t;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(FRAME_LEN - 1);

    rd_state_t         state, state_nx;
    logic              wr_bank, wr_bank_nx, rd_bank, rd_bank_nx;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx, rd_addr;
    logic [1:0]        full, full_nx;
    logic              err, err_nx, valid, valid_nx, last, last_nx;
    logic              wr_fire, wr_last, adv, issue;

    assign wr_fire = bus.s_valid & ~full[wr_bank];
    assign wr_last = wr_ptr == PTR_LAST;
    assign adv     = ~valid | bus.m_ready;
    assign issue   = (state == R_STREAM) && adv;

    assign bus.s_ready   = ~full[wr_bank];
    assign bus.ram_ena   = wr_fire;
    assign bus.ram_addra = {wr_bank, wr_ptr};
    assign bus.ram_dina  = bus.s_data;
    assign bus.ram_enb   = issue;
    assign bus.ram_addrb = {rd_bank, rd_addr};
    assign bus.m_valid   = valid;
    assign bus.m_last    = last;
    assign bus.m_data    = bus.ram_doutb;
    assign bus.bank_full = full;
    assign bus.err_len   = err;

`ifdef PINGPONG_BITREV_RD_EN
    for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
        assign rd_addr[i] = rd_ptr[ADDR_W-1-i];
    end
`else
    assign rd_addr = rd_ptr;
`endif

    always_comb begin
        state_nx   = state;
        wr_bank_nx = wr_bank;
        wr_ptr_nx  = wr_ptr;
        rd_bank_nx = rd_bank;
        rd_ptr_nx  = rd_ptr;
        full_nx    = full;
        err_nx     = err;
        valid_nx   = valid & ~bus.m_ready;
        last_nx    = last & ~bus.m_ready;
        if (wr_fire) begin
            wr_ptr_nx = wr_ptr + ADDR_W'(1);
            err_nx    = err | (bus.s_last != wr_last);
            if (wr_last) begin
                wr_bank_nx       = ~wr_bank;
                full_nx[wr_bank] = 1'b1;
            end
        end
        if (issue) begin
            rd_ptr_nx = rd_ptr + ADDR_W'(1);
            valid_nx  = 1'b1;
            last_nx   = rd_ptr == PTR_LAST;
        end
        // the writer only ever sets the bank it is filling, so this clear never collides with a set
        case (state)
            R_IDLE:   state_nx = full[rd_bank] ? R_STREAM : R_IDLE;
            R_STREAM: state_nx = (issue && rd_ptr == PTR_LAST) ? R_DRAIN : R_STREAM;
            R_DRAIN: begin
                if (valid && bus.m_ready && last) begin
                    full_nx[rd_bank] = 1'b0;
                    rd_bank_nx       = ~rd_bank;
                    rd_ptr_nx        = '0;
                    state_nx         = full[~rd_bank] ? R_STREAM : R_IDLE;
                end
            end
            default:  state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= R_IDLE;
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
            rd_bank <= 1'b0;
            rd_ptr  <= '0;
            full    <= 2'b00;
            err     <= 1'b0;
            valid   <= 1'b0;
            last    <= 1'b0;
        end else begin
            state   <= state_nx;
            wr_bank <= wr_bank_nx;
            wr_ptr  <= wr_ptr_nx;
            rd_bank <= rd_bank_nx;
            rd_ptr  <= rd_ptr_nx;
            full    <= full_nx;
            err     <= err_nx;
            valid   <= valid_nx;
            last    <= last_nx;
        end
    end
endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// tb_pingpong_ram_ctrl: random stimulus against a frame-level scoreboard, with a behavioural dual-port RAM.
module tb_pingpong_ram_ctrl;
`ifdef PINGPONG_BITREV_RD_EN
    localparam int FL = 8;
    localparam int AW = 3;
`else
    localparam int FL = 256;
    localparam int AW = 8;
`endif
    localparam int DW      = 32;
    localparam int WR_CUT  = FL > 37 ? 37 : FL / 2 + 1;
    localparam int RD_CUT  = FL > 12 ? 12 : FL / 2;
    localparam int LAST_AT = FL > 100 ? 100 : FL / 2;

    logic clk = 0;
    logic rst_n = 0;
    pingpong_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus();
    pingpong_ram_ctrl #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2*FL];
    always @(posedge clk) begin
        if (bus.ram_ena) mem[bus.ram_addra] <= bus.ram_dina;
        if (bus.ram_enb) bus.ram_doutb <= mem[bus.ram_addrb];
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fb[$];
    int wbank = 0;
    int acc = 0;
    int beat = 0;
    int rdy_mode = 0;
    logic hold = 0;
    logic [DW-1:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // beat k of a frame carries the sample written at position order(k)
    function automatic int order(input int k);
        int r = 0;
`ifdef PINGPONG_BITREV_RD_EN
        for (int b = 0; b < AW; b++) r = r * 2 + ((k >> b) & 1);
`else
        r = k;
`endif
        return r;
    endfunction

    task automatic accept(input logic [DW-1:0] d);
        chk("ram_ena", bus.ram_ena, 1);
        chk("ram_addra", bus.ram_addra, wbank * FL + fb.size());
        chk("ram_dina", bus.ram_dina, d);
        fb.push_back(d);
        acc++;
        if (fb.size() == FL) begin
            for (int k = 0; k < FL; k++) exp_q.push_back(fb[order(k)]);
            fb.delete();
            wbank ^= 1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int t = 0;
        bus.s_valid = 1;
        bus.s_data  = d;
        bus.s_last  = l;
        @(negedge clk);
        while (!bus.s_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("s_ready_wait", bus.s_ready, 1);
        if (bus.s_ready) accept(d);
        @(posedge clk);
        #1;
        bus.s_valid = 0;
        bus.s_last  = 0;
    endtask

    task automatic send_frame(input int n, input int last_at, input bit rnd, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send(rnd ? DW'($urandom) : DW'(i), i == last_at);
            if (gaps) repeat ($urandom % 3 == 0 ? $urandom % 3 : 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic reset_dut();
        rst_n = 0;
        bus.s_valid = 0;
        exp_q.delete();
        fb.delete();
        wbank = 0;
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_bank_full", bus.bank_full, 0);
        chk("rst_err_len", bus.err_len, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_ram_enb", bus.ram_enb, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    always begin
        @(posedge clk);
        #1;
        bus.m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 0;
            beat = 0;
        end else begin
            if (hold) begin
                chk("m_valid_hold", bus.m_valid, 1);
                chk("m_data_hold", bus.m_data, held);
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("m_data", bus.m_data, exp_q.pop_front());
                chk("m_last", bus.m_last, beat == FL - 1);
                beat = (beat + 1) % FL;
            end
            hold = bus.m_valid && !bus.m_ready;
            held = bus.m_data;
        end
    end

    initial begin
        int t;
        bus.s_valid = 0;
        bus.s_data  = 0;
        bus.s_last  = 0;
        bus.m_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        reset_dut();
        // single ordered frame, then the two-cycle handover latency
        send_frame(FL, FL - 1, 0, 0);
        chk("t1_bank_full", bus.bank_full, 2'b01);
        chk("t1_lat0", bus.m_valid, 0);
        @(posedge clk);
        #1;
        chk("t1_lat1", bus.m_valid, 0);
        @(posedge clk);
        #1;
        chk("t1_lat2", bus.m_valid, 1);
        wait_drain();
        chk("t1_bank_empty", bus.bank_full, 0);
        chk("t1_err_len", bus.err_len, 0);
        // reader stalled: both banks fill and the writer is blocked
        rdy_mode = 1;
        acc = 0;
        fork
            for (int f = 0; f < 3; f++) send_frame(FL, FL - 1, 1, 0);
        join_none
        t = 0;
        while (acc < 2 * FL && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("t2_accepted", acc, 2 * FL);
        chk("t2_s_ready", bus.s_ready, 0);
        chk("t2_both_full", bus.bank_full, 2'b11);
        rdy_mode = 0;
        wait fork;
        wait_drain();
        chk("t2_all_accepted", acc, 3 * FL);
        // random backpressure and input gaps
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) send_frame(FL, FL - 1, 1, 1);
        wait_drain();
        rdy_mode = 0;
        chk("t3_bank_empty", bus.bank_full, 0);
        // misplaced s_last
        chk("t4_err_before", bus.err_len, 0);
        send_frame(FL, LAST_AT, 1, 0);
        wait_drain();
        chk("t4_err_set", bus.err_len, 1);
        send_frame(FL, FL - 1, 1, 0);
        wait_drain();
        chk("t4_err_sticky", bus.err_len, 1);
        // reset mid-write, then mid-read
        send_frame(WR_CUT, -1, 1, 0);
        reset_dut();
        send_frame(FL, FL - 1, 1, 0);
        t = 0;
        while (beat < RD_CUT && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("t5_mid_read_beat", beat, RD_CUT);
        reset_dut();
        send_frame(FL, FL - 1, 1, 0);
        wait_drain();
        chk("t5_bank_empty", bus.bank_full, 0);
        chk("t5_err_len", bus.err_len, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
